// File: rtl/btn_evt_ctrl.sv
// Button event controller: per-button press classification (short/long/repeat)
// sampled on a periodic tick, merged onto one valid/ready port by a round-robin arbiter.
module btn_evt_ctrl #(
    parameter int unsigned  BTN_WIDTH    = 8,
    parameter logic         BTN_POL      = 1'b0,
    parameter int unsigned  TICK_CYCLES  = 50000,
    parameter int unsigned  LONG_TICKS   = 1000,
    parameter int unsigned  REPEAT_TICKS = 200,
    localparam int unsigned IDX_W        = (BTN_WIDTH > 1) ? $clog2(BTN_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_WIDTH-1:0] btn_deb,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDX_W-1:0]     evt_idx,
    output logic [1:0]           evt_type,
    output logic                 evt_drop,
    output logic [BTN_WIDTH-1:0] btn_held
);

    localparam int unsigned TCNT_W = $clog2(TICK_CYCLES);
    localparam int unsigned HMAX   = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned HCNT_W = $clog2(HMAX + 1);
    localparam int unsigned CAND_W = IDX_W + 1;

    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_REPEAT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_LONG = 2'd2
    } state_t;

    logic [BTN_WIDTH-1:0] sync1_q, sync2_q, pressed;
    logic [TCNT_W-1:0]    tcnt_q;
    logic                 tick;

    state_t               state_q   [BTN_WIDTH];
    state_t               state_d   [BTN_WIDTH];
    logic [HCNT_W-1:0]    hcnt_q    [BTN_WIDTH];
    logic [HCNT_W-1:0]    hcnt_d    [BTN_WIDTH];
    logic [1:0]           emit_type [BTN_WIDTH];
    logic [BTN_WIDTH-1:0] emit, held_d;

    logic [BTN_WIDTH-1:0] slot_vld_q;
    logic [1:0]           slot_typ_q [BTN_WIDTH];
    logic [BTN_WIDTH-1:0] gnt_take;
    logic [IDX_W-1:0]     rr_q, rr_d, gnt_idx;
    logic [CAND_W-1:0]    cand;
    logic                 gnt_found, load, drop_d;

    // Two-flop synchronizer; reset to the released level so nothing looks pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {BTN_WIDTH{~BTN_POL}};
            sync2_q <= {BTN_WIDTH{~BTN_POL}};
        end else begin
            sync1_q <= btn_deb;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = BTN_POL ? sync2_q : ~sync2_q;
    assign tick    = (tcnt_q == TCNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tcnt_q <= '0;
        else if (tick) tcnt_q <= '0;
        else           tcnt_q <= tcnt_q + TCNT_W'(1);
    end

    // Per-button state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                state_q[i] <= S_IDLE;
                hcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    // Press classification; hcnt saturates so a repeat-disabled hold never wraps
    always_comb begin
        for (int i = 0; i < BTN_WIDTH; i++) begin
            state_d[i]   = state_q[i];
            hcnt_d[i]    = hcnt_q[i];
            emit[i]      = 1'b0;
            emit_type[i] = 2'b00;
            if (tick) begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (pressed[i]) begin
                            state_d[i] = S_HOLD;
                            hcnt_d[i]  = HCNT_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (!pressed[i]) begin
                            state_d[i]   = S_IDLE;
                            hcnt_d[i]    = '0;
                            emit[i]      = 1'b1;
                            emit_type[i] = EVT_SHORT;
                        end else if (hcnt_q[i] == HCNT_W'(LONG_TICKS - 1)) begin
                            state_d[i]   = S_LONG;
                            hcnt_d[i]    = '0;
                            emit[i]      = 1'b1;
                            emit_type[i] = EVT_LONG;
                        end else if (hcnt_q[i] != '1) begin
                            hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
                        end
                    end
                    S_LONG: begin
                        if (!pressed[i]) begin
                            state_d[i] = S_IDLE;
                            hcnt_d[i]  = '0;
                        end else if ((REPEAT_TICKS != 0) &&
                                     (hcnt_q[i] == HCNT_W'(REPEAT_TICKS - 1))) begin
                            hcnt_d[i]    = '0;
                            emit[i]      = 1'b1;
                            emit_type[i] = EVT_REPEAT;
                        end else if (hcnt_q[i] != '1) begin
                            hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        hcnt_d[i]  = '0;
                    end
                endcase
            end
            held_d[i] = (state_d[i] != S_IDLE);
        end
    end

    // Round-robin search starting at rr_q
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < BTN_WIDTH; k++) begin
            cand = CAND_W'(rr_q) + CAND_W'(k);
            if (cand >= CAND_W'(BTN_WIDTH)) cand = cand - CAND_W'(BTN_WIDTH);
            if (!gnt_found && slot_vld_q[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign load = !evt_valid || evt_ready;
    assign rr_d = (gnt_idx == IDX_W'(BTN_WIDTH - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < BTN_WIDTH; i++) begin
            gnt_take[i] = load && gnt_found && (gnt_idx == IDX_W'(i));
        end
        drop_d = |(emit & slot_vld_q & ~gnt_take);
    end

    // A new event wins over a same-cycle grant, so the slot stays full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= '0;
            for (int i = 0; i < BTN_WIDTH; i++) slot_typ_q[i] <= 2'b00;
        end else begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                if (emit[i]) begin
                    slot_vld_q[i] <= 1'b1;
                    slot_typ_q[i] <= emit_type[i];
                end else if (gnt_take[i]) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_type  <= 2'b00;
            evt_drop  <= 1'b0;
            btn_held  <= '0;
            rr_q      <= '0;
        end else begin
            evt_drop <= drop_d;
            btn_held <= held_d;
            if (load) begin
                if (gnt_found) begin
                    evt_valid <= 1'b1;
                    evt_idx   <= gnt_idx;
                    evt_type  <= slot_typ_q[gnt_idx];
                    rr_q      <= rr_d;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule
